// File: rtl/tse_desc_pkg.sv
// Shared descriptor field widths and arbiter FSM encodings for the transmit
// descriptor path.
package tse_desc_pkg;

  localparam int TSNTAG_W   = 48;
  localparam int BUFID_W    = 9;
  localparam int DESC_W     = TSNTAG_W + BUFID_W;
  localparam int PKT_TYPE_W = 3;

  typedef enum logic [1:0] {
    IDLE_S     = 2'b01,
    WAIT_REL_S = 2'b10
  } state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: rotate the request vector so the port after
// ptr sits at bit 0, find the first set bit, then map it back to a port index.
module rr_priority_select #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [PW-1:0]        grant,
  output logic                 valid
);

  localparam logic [PW:0] NUM_C = (PW+1)'(NUM_PORTS);

  logic [PW-1:0]        rot_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] rot_req;
  logic [PW-1:0]        first;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
      logic [PW:0] sum;
      // ptr + 1 + gi never exceeds 2*NUM_PORTS-1, so one conditional subtract wraps it
      assign sum          = {1'b0, ptr} + (PW+1)'(gi + 1);
      assign rot_idx[gi]  = (sum >= NUM_C) ? PW'(sum - NUM_C) : PW'(sum);
      assign rot_req[gi]  = req[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    first = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot_req[i]) first = PW'(i);
    end
    grant = rot_idx[first];
    valid = |rot_req;
  end

endmodule

// File: rtl/descriptor_rr_arbiter.sv
// Round-robin arbiter that moves one descriptor per grant from N producers into
// the shared transmit descriptor FIFO, gated by an internal occupancy count.
module descriptor_rr_arbiter
  import tse_desc_pkg::*;
#(
  parameter int         NUM_PORTS   = 4,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] REL_TIMEOUT = 8'd255
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_PORTS-1:0]                iv_descriptor_wr,
  input  logic [NUM_PORTS*DESC_W-1:0]         iv_descriptor,
  input  logic [NUM_PORTS*PKT_TYPE_W-1:0]     iv_pkt_type,
  output logic [NUM_PORTS-1:0]                ov_descriptor_ack,
  output logic [DESC_W-1:0]                   ov_fifo_wdata,
  output logic [PKT_TYPE_W-1:0]               ov_pkt_type,
  output logic                                o_fifo_wr,
  input  logic                                i_fifo_rd,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     ov_fifo_occupancy,
  output logic                                o_credit_err,
  output logic                                o_release_timeout
);

  localparam int PW    = $clog2(NUM_PORTS);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  state_t                 state_reg, state_next;
  logic [PW-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0]          gnt_reg, gnt_next;
  logic [7:0]             tmo_reg, tmo_next;
  logic [NUM_PORTS-1:0]   stale_reg, stale_next, stale_set;
  logic [NUM_PORTS-1:0]   ack_reg, ack_next;
  logic                   wr_reg, wr_next;
  logic [DESC_W-1:0]      wdata_reg, wdata_next;
  logic [PKT_TYPE_W-1:0]  pkt_reg, pkt_next;
  logic [OCC_W-1:0]       occ_reg, occ_next;
  logic                   cerr_reg, cerr_next;
  logic                   rto_reg, rto_next;

  logic [DESC_W-1:0]      desc_arr [NUM_PORTS];
  logic [PKT_TYPE_W-1:0]  pkt_arr  [NUM_PORTS];
  logic [NUM_PORTS-1:0]   eligible;
  logic [PW-1:0]          sel_idx;
  logic                   sel_valid;
  logic [7:0]             tmo_inc;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slice
      assign desc_arr[gi] = iv_descriptor[gi*DESC_W +: DESC_W];
      assign pkt_arr[gi]  = iv_pkt_type[gi*PKT_TYPE_W +: PKT_TYPE_W];
    end
  endgenerate

  assign eligible = iv_descriptor_wr & ~stale_reg;
  assign tmo_inc  = tmo_reg + 8'd1;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_select (
    .req   (eligible),
    .ptr   (rr_ptr_reg),
    .grant (sel_idx),
    .valid (sel_valid)
  );

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    gnt_next    = gnt_reg;
    tmo_next    = tmo_reg;
    stale_set   = '0;
    ack_next    = '0;
    wr_next     = 1'b0;
    wdata_next  = '0;
    pkt_next    = '0;
    rto_next    = rto_reg;
    case (state_reg)
      IDLE_S: begin
        if (sel_valid && (occ_reg < DEPTH_C)) begin
          ack_next[sel_idx] = 1'b1;
          wr_next           = 1'b1;
          wdata_next        = desc_arr[sel_idx];
          pkt_next          = pkt_arr[sel_idx];
          rr_ptr_next       = sel_idx;
          gnt_next          = sel_idx;
          tmo_next          = 8'd0;
          state_next        = WAIT_REL_S;
        end
      end
      WAIT_REL_S: begin
        if (!iv_descriptor_wr[gnt_reg]) begin
          state_next = IDLE_S;
        end else begin
          tmo_next = tmo_inc;
          // A requester that never drops wr is parked so the others keep moving
          if (tmo_inc == REL_TIMEOUT) begin
            stale_set[gnt_reg] = 1'b1;
            rto_next           = 1'b1;
            state_next         = IDLE_S;
          end
        end
      end
      default: state_next = IDLE_S;
    endcase
  end

  assign stale_next = (stale_reg | stale_set) & iv_descriptor_wr;

  always_comb begin
    occ_next  = occ_reg;
    cerr_next = cerr_reg;
    if (wr_reg && !i_fifo_rd) begin
      occ_next = occ_reg + 1'b1;
    end else if (!wr_reg && i_fifo_rd) begin
      if (occ_reg == '0) cerr_next = 1'b1;
      else               occ_next  = occ_reg - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= IDLE_S;
      rr_ptr_reg <= PW'(NUM_PORTS - 1);
      gnt_reg    <= '0;
      tmo_reg    <= '0;
      stale_reg  <= '0;
      ack_reg    <= '0;
      wr_reg     <= 1'b0;
      wdata_reg  <= '0;
      pkt_reg    <= '0;
      occ_reg    <= '0;
      cerr_reg   <= 1'b0;
      rto_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      gnt_reg    <= gnt_next;
      tmo_reg    <= tmo_next;
      stale_reg  <= stale_next;
      ack_reg    <= ack_next;
      wr_reg     <= wr_next;
      wdata_reg  <= wdata_next;
      pkt_reg    <= pkt_next;
      occ_reg    <= occ_next;
      cerr_reg   <= cerr_next;
      rto_reg    <= rto_next;
    end
  end

  assign ov_descriptor_ack = ack_reg;
  assign o_fifo_wr         = wr_reg;
  assign ov_fifo_wdata     = wdata_reg;
  assign ov_pkt_type       = pkt_reg;
  assign ov_fifo_occupancy = occ_reg;
  assign o_credit_err      = cerr_reg;
  assign o_release_timeout = rto_reg;

endmodule
